// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder and other uart_send /
// uart_rec clients: byte width and the feeder FSM state encodings.
package uart_tx_feeder_pkg;

    localparam int BYTE_W = 8;

    // FSM states (kept as plain constants so legacy users can share them)
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

endpackage

// File: rtl/uart_tx_feeder_sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head output.
// Ports:
//   clk, rst_n      clock, async active-low reset
//   push, push_data write request and data (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   head            oldest stored word, valid whenever !empty
//   full, empty     occupancy flags
//   level           occupancy 0..DEPTH
module uart_tx_feeder_sync_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [DW-1:0] head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push, do_pop;

    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push into a full FIFO is allowed when a pop frees a slot this cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // DEPTH is a power of two, so the pointers wrap naturally.
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// UART transmit feeder: buffers bytes from producers and hands them one at a
// time to uart_send (send_en pulse + data_out), waiting for tx_done between
// frames. A watchdog abandons a frame whose tx_done never arrives.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   wr_en, wr_data        byte push from producers
//   full, empty, level    FIFO status
//   ovf, ovf_clr          sticky dropped-write flag and its clear
//   send_en, data_out     start pulse and byte towards uart_send
//   tx_done, tx_state     end-of-frame pulse and busy status from uart_send
//   busy                  FSM not idle
//   to_err                sticky watchdog flag (reset only)
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    output logic              full,
    output logic              empty,
    output logic [AW:0]       level,
    output logic              ovf,
    input  logic              ovf_clr,
    output logic              send_en,
    output logic [BYTE_W-1:0] data_out,
    input  logic              tx_done,
    input  logic              tx_state,
    output logic              busy,
    output logic              to_err
);

    localparam int WD_W = $clog2(TIMEOUT);
    // The abort fires on the edge where the counter would step to TIMEOUT-1,
    // which puts the return to IDLE exactly TIMEOUT cycles after send_en.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 2);

    logic [1:0]        state_q,    state_d;
    logic              send_en_q,  send_en_d;
    logic [BYTE_W-1:0] data_out_q, data_out_d;
    logic [WD_W-1:0]   wd_q,       wd_d;
    logic              ovf_q,      ovf_d;
    logic              to_err_q,   to_err_d;

    logic              pop, push;
    logic [BYTE_W-1:0] head;
    logic              fifo_full, fifo_empty;

    // tx_state is informational only; sequencing relies on tx_done.
    logic unused_tx_state;
    assign unused_tx_state = tx_state;

    assign push = wr_en && (!fifo_full || pop);

    uart_tx_feeder_sync_fifo #(
        .DW    (BYTE_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (wr_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (level)
    );

    always_comb begin
        state_d    = state_q;
        send_en_d  = 1'b0;
        data_out_d = data_out_q;
        wd_d       = wd_q;
        to_err_d   = to_err_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    data_out_d = head;
                    // Registered so the pulse lines up with the ISSUE cycle.
                    send_en_d  = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                wd_d    = '0;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // tx_done has priority over a coincident timeout.
                if (tx_done) begin
                    state_d = IDLE;
                end else if (wd_q == WD_LAST) begin
                    to_err_d = 1'b1;
                    state_d  = IDLE;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ovf_d = ovf_clr ? 1'b0 : ovf_q;
        // A same-cycle overflow wins over the clear.
        if (wr_en && fifo_full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            send_en_q  <= 1'b0;
            data_out_q <= '0;
            wd_q       <= '0;
            ovf_q      <= 1'b0;
            to_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            send_en_q  <= send_en_d;
            data_out_q <= data_out_d;
            wd_q       <= wd_d;
            ovf_q      <= ovf_d;
            to_err_q   <= to_err_d;
        end
    end

    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign ovf      = ovf_q;
    assign send_en  = send_en_q;
    assign data_out = data_out_q;
    assign busy     = (state_q != IDLE);
    assign to_err   = to_err_q;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder (DEPTH=16, TIMEOUT=64).
module tb_uart_tx_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       ovf_clr = 1'b0;
    logic       tx_done = 1'b0;
    logic       tx_state = 1'b0;
    logic       full, empty, ovf, send_en, busy, to_err;
    logic [4:0] level;
    logic [7:0] data_out;

    int errors = 0;
    int checks = 0;
    int send_cnt = 0;
    int c0;

    always #5 clk = ~clk;

    uart_tx_feeder #(.DEPTH(16), .AW(4), .TIMEOUT(64)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr),
        .send_en  (send_en),
        .data_out (data_out),
        .tx_done  (tx_done),
        .tx_state (tx_state),
        .busy     (busy),
        .to_err   (to_err)
    );

    // Count send_en pulses mid-cycle.
    always @(negedge clk) if (send_en === 1'b1) send_cnt <= send_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        step();
        wr_en = 1'b0;
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        tx_state = 1'b0;
        step();
        tx_done = 1'b0;
    endtask

    initial begin
        // ---------------- reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_level", level, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_to_err", to_err, 0);
        chk("rst_send_en", send_en, 0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        step();

        // ---------------- single byte
        write_byte(8'hA5);
        chk("s1_level_after_wr", level, 1);
        chk("s1_no_send_yet", send_en, 0);
        step();
        chk("s1_send_en", send_en, 1);
        chk("s1_data_out", data_out, 8'hA5);
        chk("s1_busy", busy, 1);
        chk("s1_empty_after_pop", empty, 1);
        tx_state = 1'b1;
        step();
        chk("s1_send_en_one_cycle", send_en, 0);
        chk("s1_busy_wait", busy, 1);
        repeat (47) step();
        chk("s1_still_busy", busy, 1);
        pulse_done();
        chk("s1_idle_after_done", busy, 0);
        chk("s1_empty_end", empty, 1);
        chk("s1_data_hold", data_out, 8'hA5);

        // tx_done while idle is ignored
        pulse_done();
        step();
        chk("idle_done_busy", busy, 0);
        chk("idle_done_send", send_en, 0);
        chk("idle_done_to_err", to_err, 0);

        // ---------------- burst 01..04
        c0 = send_cnt;
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'(i + 1);
            step();
            if (i == 1) chk("b_first_send", data_out, 8'h01);
        end
        wr_en = 1'b0;
        chk("b_level_3", level, 3);
        for (int i = 1; i < 4; i++) begin
            repeat (5) step();
            pulse_done();
            chk("b_no_send_on_done", send_en, 0);
            chk("b_idle_on_done", busy, 0);
            step();
            chk("b_send_en", send_en, 1);
            chk("b_data", data_out, 32'(i + 1));
            chk("b_level", level, 32'(3 - i));
        end
        repeat (3) step();
        pulse_done();
        repeat (3) step();
        chk("b_pulse_count", send_cnt - c0, 4);
        chk("b_empty_end", empty, 1);
        chk("b_idle_end", busy, 0);

        // ---------------- overflow while held in WAIT_DONE
        write_byte(8'hEE);
        step();
        chk("o_send_ee", data_out, 8'hEE);
        wr_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(8'h10 + i);
            step();
        end
        chk("o_full_16", full, 1);
        chk("o_level_16", level, 16);
        chk("o_no_ovf_yet", ovf, 0);
        wr_data = 8'h20;
        step();
        wr_en = 1'b0;
        chk("o_ovf_set", ovf, 1);
        chk("o_level_still_16", level, 16);
        // clear with a concurrent overflow: stays set
        wr_en = 1'b1;
        wr_data = 8'h30;
        ovf_clr = 1'b1;
        step();
        wr_en = 1'b0;
        chk("o_clr_vs_ovf", ovf, 1);
        step();
        ovf_clr = 1'b0;
        chk("o_ovf_cleared", ovf, 0);
        chk("o_busy_wait", busy, 1);

        // ---------------- full with push and pop together
        pulse_done();
        chk("fp_idle", busy, 0);
        wr_en = 1'b1;
        wr_data = 8'h21;
        step();
        wr_en = 1'b0;
        chk("fp_level_16", level, 16);
        chk("fp_full", full, 1);
        chk("fp_no_ovf", ovf, 0);
        chk("fp_send", send_en, 1);
        chk("fp_data", data_out, 8'h10);
        for (int i = 0; i < 16; i++) begin
            repeat (2) step();
            pulse_done();
            step();
            chk("fp_drain_send", send_en, 1);
            chk("fp_drain_data", data_out, (i < 15) ? 32'(8'h11 + i) : 32'h21);
            chk("fp_drain_level", level, 32'(15 - i));
        end
        repeat (2) step();
        pulse_done();
        repeat (3) step();
        chk("fp_empty_end", empty, 1);
        chk("fp_idle_end", busy, 0);

        // ---------------- timeout
        write_byte(8'h55);
        step();
        chk("t_send", send_en, 1);
        chk("t_data", data_out, 8'h55);
        write_byte(8'h66);
        repeat (62) step();
        chk("t_no_err_yet", to_err, 0);
        chk("t_busy_before", busy, 1);
        step();
        chk("t_to_err", to_err, 1);
        chk("t_idle", busy, 0);
        chk("t_no_send", send_en, 0);
        step();
        chk("t_next_send", send_en, 1);
        chk("t_next_data", data_out, 8'h66);
        step();
        chk("t_err_sticky", to_err, 1);

        // ---------------- reset mid-frame
        wr_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = 8'(8'h71 + i);
            step();
        end
        wr_en = 1'b0;
        chk("r_level_3", level, 3);
        chk("r_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("r_level_0", level, 0);
        chk("r_busy_0", busy, 0);
        chk("r_send_0", send_en, 0);
        chk("r_data_0", data_out, 8'h00);
        chk("r_to_err_0", to_err, 0);
        chk("r_empty", empty, 1);
        @(negedge clk);
        rst_n = 1'b1;
        c0 = send_cnt;
        repeat (10) step();
        chk("r_no_send_after", send_cnt - c0, 0);
        write_byte(8'h99);
        step();
        chk("r_new_send", send_en, 1);
        chk("r_new_data", data_out, 8'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
